// File: rtl/lfsr_encrypt_seq.sv
// lfsr_encrypt_seq: hardware sequencer for the message-encryption program.
// After a launch request it takes over the data-memory port. It first reads three config bytes:
// pre_length, tap pattern and LFSR seed. It then produces NCHAR output bytes. Each output byte is
// the message byte XOR the 7-bit LFSR keystream, with bit 7 forced to 0. The LFSR steps once per
// character.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   init         synchronous active-high reset, aborts a run immediately
//   req          launch control: high = hold, low = run (sampled in IDLE and DONE only)
//   ack          registered run-complete flag, high while in DONE
//   busy         high whenever the sequencer is neither IDLE nor DONE
//   mem_addr     data-memory address
//   mem_rd_en    read strobe; data returns on mem_rd_data one cycle later
//   mem_rd_data  read data from the memory
//   mem_wr_en    write strobe; the memory commits on the rising edge
//   mem_wr_data  write data
`timescale 1ns/1ps

module lfsr_encrypt_seq #(
    parameter int unsigned NCHAR    = 64,
    parameter int unsigned MSG_MAX  = 54,
    parameter int unsigned CFG_BASE = 61,
    parameter int unsigned OUT_BASE = 64
) (
    input  logic       clk,
    input  logic       init,
    input  logic       req,
    output logic       ack,
    output logic       busy,
    output logic [7:0] mem_addr,
    output logic       mem_rd_en,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    typedef enum logic [2:0] {
        StIdle,
        StCfg0,
        StCfg1,
        StCfg2,
        StCfg3,
        StRd,
        StWr,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  pre_q, pre_d;
    logic [7:0]  tap_q, tap_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [6:0]  idx_q, idx_d;
    logic        ack_q, ack_d;
    // Records whether the RD cycle actually issued a read. Outside the message window the
    // character is 0 and mem_rd_data holds stale data, so it must be ignored.
    logic        rd_valid_q, rd_valid_d;

    logic signed [8:0] k;
    logic              in_window;
    logic [7:0]        ch;

    // Message offset for the current character. It can be negative or run past the message.
    assign k         = $signed({2'b00, idx_q}) - $signed({1'b0, pre_q});
    assign in_window = !k[8] && (k[7:0] < 8'(MSG_MAX));
    assign ch        = rd_valid_q ? mem_rd_data : 8'h00;

    assign ack = ack_q;

    always_ff @(posedge clk) begin
        if (init) begin
            state_q    <= StIdle;
            pre_q      <= 8'h00;
            tap_q      <= 8'h00;
            lfsr_q     <= 8'h00;
            idx_q      <= 7'd0;
            ack_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            tap_q      <= tap_d;
            lfsr_q     <= lfsr_d;
            idx_q      <= idx_d;
            ack_q      <= ack_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        tap_d       = tap_q;
        lfsr_d      = lfsr_q;
        idx_d       = idx_q;
        rd_valid_d  = 1'b0;
        mem_addr    = 8'h00;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (!req) begin
                    state_d = StCfg0;
                end
            end
            StCfg0: begin
                mem_addr  = 8'(CFG_BASE);
                mem_rd_en = 1'b1;
                state_d   = StCfg1;
            end
            StCfg1: begin
                mem_addr  = 8'(CFG_BASE + 1);
                mem_rd_en = 1'b1;
                pre_d     = mem_rd_data;
                state_d   = StCfg2;
            end
            StCfg2: begin
                mem_addr  = 8'(CFG_BASE + 2);
                mem_rd_en = 1'b1;
                tap_d     = mem_rd_data;
                state_d   = StCfg3;
            end
            StCfg3: begin
                lfsr_d  = mem_rd_data;
                idx_d   = 7'd0;
                state_d = StRd;
            end
            StRd: begin
                if (in_window) begin
                    mem_addr  = k[7:0];
                    mem_rd_en = 1'b1;
                end
                rd_valid_d = in_window;
                state_d    = StWr;
            end
            StWr: begin
                mem_addr    = 8'(OUT_BASE) + {1'b0, idx_q};
                mem_wr_en   = 1'b1;
                mem_wr_data = {1'b0, ch[6:0] ^ lfsr_q[6:0]};
                lfsr_d      = {1'b0, lfsr_q[5:0], ^(lfsr_q & tap_q)};
                idx_d       = idx_q + 7'd1;
                state_d     = (idx_q == 7'(NCHAR - 1)) ? StDone : StRd;
            end
            StDone: begin
                if (req) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ack_d = (state_d == StDone);
        busy  = !((state_q == StIdle) || (state_q == StDone));
    end

endmodule

// File: tb/tb_lfsr_encrypt_seq.sv
// Self-checking bench for lfsr_encrypt_seq. It models the data memory and computes the expected
// ciphertext from the keystream rules with plain integer arithmetic.
`timescale 1ns/1ps

module tb_lfsr_encrypt_seq;

    logic       clk = 1'b0;
    logic       init;
    logic       req;
    logic       ack;
    logic       busy;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rd_data = 8'h00;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] dm [0:255];
    logic [7:0] msg [0:53];
    logic [7:0] expv [0:63];
    int         wr_strobes = 0;
    int         bad_reads  = 0;

    logic [7:0] taps [0:8] = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};

    always #5 clk = ~clk;

    lfsr_encrypt_seq dut (
        .clk         (clk),
        .init        (init),
        .req         (req),
        .ack         (ack),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    // Data memory: synchronous read, write committed on the rising edge.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            dm[mem_addr] <= mem_wr_data;
            wr_strobes   <= wr_strobes + 1;
        end
        if (mem_rd_en) begin
            mem_rd_data <= dm[mem_addr];
            if (!((mem_addr < 8'd54) || ((mem_addr >= 8'd61) && (mem_addr <= 8'd63)))) begin
                bad_reads <= bad_reads + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected output: message byte (or 0 outside the window) XOR the keystream, bit 7 dropped.
    task automatic model(input int pre, input logic [7:0] tap, input logic [7:0] seed);
        int l;
        int ch;
        int fb;
        l = int'(seed);
        for (int i = 0; i < 64; i++) begin
            ch = ((i >= pre) && (i - pre < 54)) ? int'(msg[i - pre]) : 0;
            expv[i] = 8'((ch ^ l) & 'h7F);
            fb = $countones(l & int'(tap)) % 2;
            l = ((l * 2) & 'h7E) | fb;
        end
    endtask

    task automatic fill_msg(input int len);
        for (int a = 0; a < 54; a++) begin
            msg[a] = (a < len) ? 8'($urandom_range(8'h7E, 8'h20) - 8'h20) : 8'h00;
        end
    endtask

    task automatic load(input int pre, input logic [7:0] tap, input logic [7:0] seed);
        for (int a = 0; a < 54; a++) dm[a] <= msg[a];
        dm[61] <= 8'(pre);
        dm[62] <= tap;
        dm[63] <= seed;
        for (int a = 64; a < 128; a++) dm[a] <= 8'hAA;
        @(negedge clk);
    endtask

    task automatic wait_ack(input string tag, inout int edges);
        while (!ack && edges < 400) begin
            @(posedge clk);
            edges++;
            #1;
        end
        check({tag, "_ack_seen"}, 32'(ack), 32'd1);
    endtask

    task automatic compare_out(input string tag);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("%s_dm%0d", tag, 64 + i), 32'(dm[64 + i]), 32'(expv[i]));
        end
    endtask

    // Pulse launch low for one edge, then run to completion and compare all outputs.
    task automatic run_case(input string tag, input int pre, input logic [7:0] tap,
                            input logic [7:0] seed);
        int edges;
        int rd0;
        int wr0;
        load(pre, tap, seed);
        model(pre, tap, seed);
        rd0 = bad_reads;
        wr0 = wr_strobes;
        req = 1'b0;
        @(posedge clk);
        edges = 1;
        #1;
        check({tag, "_busy_after_launch"}, 32'(busy), 32'd1);
        @(negedge clk);
        req = 1'b1;
        wait_ack(tag, edges);
        check({tag, "_ack_latency"}, 32'(edges), 32'd133);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        compare_out(tag);
        check({tag, "_bad_reads"}, 32'(bad_reads - rd0), 32'd0);
        check({tag, "_wr_strobes"}, 32'(wr_strobes - wr0), 32'd64);
        @(posedge clk);
        #1;
        check({tag, "_ack_drop"}, 32'(ack), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int guard;
        int good;
        int edges;
        int wr0;
        int pre;

        init = 1'b1;
        req  = 1'b1;
        for (int a = 0; a < 256; a++) dm[a] <= 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_data", 32'(mem_wr_data), 32'd0);
        @(negedge clk);
        init = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_hold_busy", 32'(busy), 32'd0);

        // Directed run with known keystream values.
        for (int a = 0; a < 54; a++) msg[a] = 8'h00;
        msg[0] = 8'h2D;
        msg[1] = 8'h52;
        run_case("basic", 10, 8'h60, 8'h01);
        check("basic_dm64", 32'(dm[64]), 32'h01);
        check("basic_dm70", 32'(dm[70]), 32'h41);
        check("basic_dm73", 32'(dm[73]), 32'h0C);
        check("basic_dm74", 32'(dm[74]), 32'h35);
        check("basic_dm75", 32'(dm[75]), 32'h62);

        // Seed with bit 7 set.
        run_case("seed_ff", 10, 8'h60, 8'hFF);
        check("seed_ff_dm64", 32'(dm[64]), 32'h7F);
        check("seed_ff_dm65", 32'(dm[65]), 32'h7E);

        // Randomized full runs.
        for (int r = 0; r < 3; r++) begin
            fill_msg(41);
            run_case($sformatf("rand%0d", r), int'($urandom_range(26, 10)),
                     taps[$urandom_range(8, 0)], 8'($urandom_range(255, 0)));
        end

        // Window edges: pre=0 and pre=60 with a full-length message.
        fill_msg(54);
        run_case("pre0", 0, 8'h48, 8'h3C);
        check("pre0_first", 32'(dm[64]), 32'((msg[0] ^ 8'h3C) & 8'h7F));
        fill_msg(54);
        run_case("pre60", 60, 8'h72, 8'h55);

        // Abort with init during the 20th WR cycle.
        fill_msg(41);
        load(12, 8'h60, 8'h5A);
        model(12, 8'h60, 8'h5A);
        req = 1'b0;
        @(negedge clk);
        req = 1'b1;
        cnt = 0;
        guard = 0;
        while (cnt < 20 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (mem_wr_en) cnt++;
        end
        check("abort_found_wr20", 32'(cnt), 32'd20);
        init = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wr_en", 32'(mem_wr_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        @(negedge clk);
        init = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);
        good = 0;
        for (int a = 84; a < 128; a++) if (dm[a] === 8'hAA) good++;
        check("abort_untouched", 32'(good), 32'd44);
        good = 0;
        for (int i = 0; i < 20; i++) if (dm[64 + i] === expv[i]) good++;
        check("abort_written", 32'(good), 32'd20);

        // Hold req low after completion: no relaunch until req returns high then low.
        fill_msg(41);
        pre = int'($urandom_range(26, 10));
        load(pre, 8'h69, 8'h21);
        model(pre, 8'h69, 8'h21);
        wr0 = wr_strobes;
        req = 1'b0;
        edges = 0;
        wait_ack("hold", edges);
        repeat (40) @(negedge clk);
        check("hold_ack", 32'(ack), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);
        check("hold_strobes", 32'(wr_strobes - wr0), 32'd64);
        compare_out("hold");
        req = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_ack", 32'(ack), 32'd0);
        check("hold_release_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("hold_idle_busy", 32'(busy), 32'd0);
        req = 1'b0;
        @(posedge clk);
        #1;
        check("relaunch_busy", 32'(busy), 32'd1);
        @(negedge clk);
        req = 1'b1;
        edges = 1;
        wait_ack("relaunch", edges);
        check("relaunch_latency", 32'(edges), 32'd133);
        check("relaunch_strobes", 32'(wr_strobes - wr0), 32'd128);
        compare_out("relaunch");
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
